// File: rtl/coeff_loader_if.sv
// Handshake bundle shared by the coefficient loader, the register block and the FIR controller.
// The master side is the loader; the slave side is everything around it.
interface coeff_loader_if #(
   parameter int NUM_COEFFS = 4
);
   localparam int CW = $clog2(NUM_COEFFS);

   logic          new_coefficient_set;
   logic          modwait;
   logic          load_coeff;
   logic [CW-1:0] coefficient_num;
   logic          clear_new_coeff;
   logic          busy;
   logic          err;

   modport master (
      input  new_coefficient_set,
      input  modwait,
      output load_coeff,
      output coefficient_num,
      output clear_new_coeff,
      output busy,
      output err
   );

   modport slave (
      output new_coefficient_set,
      output modwait,
      input  load_coeff,
      input  coefficient_num,
      input  clear_new_coeff,
      input  busy,
      input  err
   );
endinterface

// File: rtl/coeff_loader.sv
// Coefficient loader: walks a pending coefficient set into the FIR controller one entry at a
// time, pulsing load_coeff and waiting for a full modwait rise/fall before the next entry.
// Every output is a flop, so nothing on the output side depends combinationally on an input.
module coeff_loader #(
   parameter int NUM_COEFFS = 4,
   parameter int TIMEOUT    = 16
) (
   input  logic           clk,
   input  logic           rst,
   coeff_loader_if.master bus
);
   localparam int CW = $clog2(NUM_COEFFS);
   localparam int TW = $clog2(TIMEOUT + 1);

   localparam logic [CW-1:0] LAST_IDX   = CW'(NUM_COEFFS - 1);
   localparam logic [TW-1:0] TCNT_LIMIT = TW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_WAIT_HI,
      S_WAIT_LO,
      S_DONE,
      S_ERR
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] idx_q, idx_d;
   logic [TW-1:0] tcnt_q, tcnt_d;

   logic load_coeff_q, load_coeff_d;
   logic clear_new_coeff_q, clear_new_coeff_d;
   logic busy_q, busy_d;
   logic err_q, err_d;

   // Next-state logic: sequencing, index advance and the per-edge handshake timeout.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      tcnt_d  = tcnt_q;

      unique case (state_q)
         S_IDLE: begin
            // A busy controller defers the start; the request simply waits.
            if (bus.new_coefficient_set && !bus.modwait) begin
               idx_d   = '0;
               state_d = S_LOAD;
            end
         end

         S_LOAD: begin
            tcnt_d  = '0;
            state_d = S_WAIT_HI;
         end

         S_WAIT_HI: begin
            if (bus.modwait) begin
               tcnt_d  = '0;
               state_d = S_WAIT_LO;
            end else if (tcnt_q == TCNT_LIMIT) begin
               state_d = S_ERR;
            end else begin
               tcnt_d = tcnt_q + 1'b1;
            end
         end

         S_WAIT_LO: begin
            if (!bus.modwait) begin
               if (idx_q == LAST_IDX) begin
                  state_d = S_DONE;
               end else begin
                  idx_d   = idx_q + 1'b1;
                  state_d = S_LOAD;
               end
            end else if (tcnt_q == TCNT_LIMIT) begin
               state_d = S_ERR;
            end else begin
               tcnt_d = tcnt_q + 1'b1;
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         S_ERR: begin
            // The pending flag is left alone so the whole set is retried from entry 0.
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Output decode from the next state, so the registered outputs track the registered state.
   always_comb begin
      load_coeff_d      = (state_d == S_LOAD);
      clear_new_coeff_d = (state_d == S_DONE);
      err_d             = (state_d == S_ERR);
      busy_d            = (state_d != S_IDLE);
   end

   // State, counters and output flops; reset returns everything to an idle, quiet loader.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q           <= S_IDLE;
         idx_q             <= '0;
         tcnt_q            <= '0;
         load_coeff_q      <= 1'b0;
         clear_new_coeff_q <= 1'b0;
         busy_q            <= 1'b0;
         err_q             <= 1'b0;
      end else begin
         state_q           <= state_d;
         idx_q             <= idx_d;
         tcnt_q            <= tcnt_d;
         load_coeff_q      <= load_coeff_d;
         clear_new_coeff_q <= clear_new_coeff_d;
         busy_q            <= busy_d;
         err_q             <= err_d;
      end
   end

   assign bus.load_coeff      = load_coeff_q;
   assign bus.coefficient_num = idx_q;
   assign bus.clear_new_coeff = clear_new_coeff_q;
   assign bus.busy            = busy_q;
   assign bus.err             = err_q;

   // Two loads always have at least a WAIT_HI and a WAIT_LO cycle between them.
   a_load_spacing: assert property (@(posedge clk) disable iff (rst)
      load_coeff_q |=> !load_coeff_q ##1 !load_coeff_q);

   // Load, completion and error pulses belong to different states and never overlap.
   a_pulses_exclusive: assert property (@(posedge clk) disable iff (rst)
      $onehot0({load_coeff_q, clear_new_coeff_q, err_q}));

   // Any pulse comes from a non-idle state.
   a_pulse_when_busy: assert property (@(posedge clk) disable iff (rst)
      (load_coeff_q || clear_new_coeff_q || err_q) |-> busy_q);
endmodule

// File: tb/tb_coeff_loader.sv
// Bench for coeff_loader: a hand-written vector table for reset and the nominal load, then
// directed corner sequences and a random run, all checked every cycle against a schedule
// model that predicts pulse times from the controller's response delays.
`timescale 1ns/1ps
module tb_coeff_loader;
   localparam int NUM_COEFFS = 4;
   localparam int TIMEOUT    = 16;
   localparam int CW         = $clog2(NUM_COEFFS);
   localparam int NEVER      = 100000;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   coeff_loader_if #(.NUM_COEFFS(NUM_COEFFS)) bus ();

   coeff_loader #(.NUM_COEFFS(NUM_COEFFS), .TIMEOUT(TIMEOUT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          rst;
      logic          nsf;
      logic          mw;
      logic          load;
      logic [CW-1:0] num;
      logic          clear;
      logic          busy;
      logic          err;
   } vec_t;

   vec_t vecs[$];

   // Stimulus knobs and register-block / controller emulation state.
   logic rst_drv      = 1'b0;
   logic nsf_reg      = 1'b0;
   logic force_mw     = 1'b0;
   logic scen_random  = 1'b0;
   int   scen_d1      = 1;
   int   scen_h       = 1;
   int   silent_coeff = -1;
   int   ctl_rise     = 0;
   int   ctl_fall     = 0;
   int   ctl_k        = 0;

   // Schedule model of the current coefficient set.
   logic active   = 1'b0;
   logic plan_err = 1'b0;
   int   plan_s   = 0;
   int   end_at   = 0;
   int   n_loads  = 0;
   int   prev_idx = 0;
   int   load_at[NUM_COEFFS];
   int   pd1[NUM_COEFFS];
   int   ph[NUM_COEFFS];

   int obs_load_cyc[$];
   int obs_load_num[$];
   int obs_clear_cyc[$];
   int obs_err_cyc[$];

   function automatic logic [CW+3:0] dut_outs();
      return {bus.load_coeff, bus.coefficient_num, bus.clear_new_coeff, bus.busy, bus.err};
   endfunction

   task automatic check_output(input string name, input logic [CW+3:0] act,
                               input logic [CW+3:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s cycle %0d: got load=%b num=%0d clear=%b busy=%b err=%b, want load=%b num=%0d clear=%b busy=%b err=%b",
                  name, cyc, act[CW+3], act[CW+2:3], act[2], act[1], act[0],
                  exp[CW+3], exp[CW+2:3], exp[2], exp[1], exp[0]);
      end
   endtask

   task automatic check_value(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("[TB] FAIL %s cycle %0d: got %0d, want %0d", name, cyc, act, exp);
      end
   endtask

   task automatic add_vec(input logic r, input logic n, input logic m, input logic ld,
                          input int num, input logic cl, input logic bz, input logic er);
      vec_t v;
      v.rst   = r;
      v.nsf   = n;
      v.mw    = m;
      v.load  = ld;
      v.num   = CW'(num);
      v.clear = cl;
      v.busy  = bz;
      v.err   = er;
      vecs.push_back(v);
   endtask

   task automatic apply_vector(input vec_t v);
      @(posedge clk);
      #1;
      cyc++;
      rst                     = v.rst;
      bus.new_coefficient_set = v.nsf;
      bus.modwait             = v.mw;
      @(negedge clk);
      check_output("vector", dut_outs(), {v.load, v.num, v.clear, v.busy, v.err});
   endtask

   // Predict the set's timeline from the controller's per-entry delays: rise d1 cycles after
   // a load, stay high h cycles; a silent rise or an over-long high phase ends in a timeout.
   function automatic void make_plan(input int s);
      int   t;
      int   rise;
      logic stop;
      plan_s   = s;
      active   = 1'b1;
      plan_err = 1'b0;
      ctl_k    = 0;
      stop     = 1'b0;
      for (int i = 0; i < NUM_COEFFS; i++) begin
         if (scen_random) begin
            pd1[i] = ($urandom_range(0, 9) == 0) ? TIMEOUT + int'($urandom_range(1, 4))
                                                 : int'($urandom_range(1, 3));
            ph[i]  = ($urandom_range(0, 9) == 0) ? TIMEOUT + int'($urandom_range(1, 3))
                                                 : int'($urandom_range(1, 6));
         end else begin
            pd1[i] = scen_d1;
            ph[i]  = scen_h;
         end
      end
      if (silent_coeff >= 0) begin
         pd1[silent_coeff] = NEVER;
         silent_coeff      = -1;
      end
      t       = s + 1;
      n_loads = 0;
      for (int i = 0; i < NUM_COEFFS; i++) begin
         if (!stop) begin
            load_at[i] = t;
            n_loads    = i + 1;
            rise       = t + pd1[i];
            if (pd1[i] > TIMEOUT) begin
               plan_err = 1'b1;
               end_at   = t + TIMEOUT + 1;
               stop     = 1'b1;
            end else if (ph[i] - 1 >= TIMEOUT) begin
               plan_err = 1'b1;
               end_at   = rise + TIMEOUT + 1;
               stop     = 1'b1;
            end else begin
               t = rise + ph[i] + 1;
            end
         end
      end
      if (!plan_err) end_at = t;
   endfunction

   function automatic logic [CW+3:0] model_expect();
      logic          ld, cl, bz, er;
      logic [CW-1:0] num;
      ld  = 1'b0;
      cl  = 1'b0;
      bz  = 1'b0;
      er  = 1'b0;
      num = CW'(prev_idx);
      if (active && cyc > plan_s) begin
         bz = 1'b1;
         for (int i = 0; i < n_loads; i++) begin
            if (load_at[i] <= cyc) num = CW'(i);
            if (load_at[i] == cyc) ld = 1'b1;
         end
         cl = !plan_err && (cyc == end_at);
         er = plan_err && (cyc == end_at);
      end
      return {ld, num, cl, bz, er};
   endfunction

   // One clock of closed-loop stimulus: drive, check against the model, let the emulated
   // controller and register block react, then advance the model.
   task automatic apply_stimulus();
      logic mw;
      logic nsf_now;
      @(posedge clk);
      #1;
      cyc++;
      mw                      = force_mw || ((cyc >= ctl_rise) && (cyc < ctl_fall));
      nsf_now                 = nsf_reg;
      rst                     = rst_drv;
      bus.new_coefficient_set = nsf_now;
      bus.modwait             = mw;
      @(negedge clk);
      check_output("model", dut_outs(), model_expect());
      if (bus.load_coeff) begin
         obs_load_cyc.push_back(cyc);
         obs_load_num.push_back(int'(bus.coefficient_num));
         if (ctl_k < NUM_COEFFS) begin
            ctl_rise = cyc + pd1[ctl_k];
            ctl_fall = ctl_rise + ph[ctl_k];
         end else begin
            ctl_rise = cyc + 1;
            ctl_fall = cyc + 2;
         end
         ctl_k++;
      end
      if (bus.clear_new_coeff) begin
         obs_clear_cyc.push_back(cyc);
         nsf_reg = 1'b0;
      end
      if (bus.err) obs_err_cyc.push_back(cyc);
      if (rst_drv) begin
         active   = 1'b0;
         prev_idx = 0;
         ctl_rise = 0;
         ctl_fall = 0;
      end else if (active && cyc == end_at) begin
         active   = 1'b0;
         prev_idx = n_loads - 1;
      end else if (!active && nsf_now && !mw) begin
         make_plan(cyc);
      end
   endtask

   task automatic do_reset();
      nsf_reg  = 1'b0;
      force_mw = 1'b0;
      rst_drv  = 1'b1;
      apply_stimulus();
      rst_drv  = 1'b0;
      apply_stimulus();
   endtask

   task automatic clear_obs();
      obs_load_cyc.delete();
      obs_load_num.delete();
      obs_clear_cyc.delete();
      obs_err_cyc.delete();
   endtask

   task automatic run_until_idle(input string name, input int max_cycles);
      int n;
      n = 0;
      while ((bus.busy || nsf_reg) && n < max_cycles) begin
         apply_stimulus();
         n++;
      end
      check_value(name, int'({bus.busy, nsf_reg}), 0);
   endtask

   initial begin
      bus.new_coefficient_set = 1'b0;
      bus.modwait             = 1'b0;

      // Reset, idle, then a nominal four-entry load with the controller answering 1 then 0.
      add_vec(1, 0, 0, 0, 0, 0, 0, 0);
      add_vec(1, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 10; i++) add_vec(0, 0, 0, 0, 0, 0, 0, 0);
      add_vec(0, 1, 0, 0, 0, 0, 0, 0);
      for (int k = 0; k < NUM_COEFFS; k++) begin
         add_vec(0, 1, 0, 1, k, 0, 1, 0);
         add_vec(0, 1, 1, 0, k, 0, 1, 0);
         add_vec(0, 1, 0, 0, k, 0, 1, 0);
      end
      add_vec(0, 1, 0, 0, NUM_COEFFS - 1, 1, 1, 0);
      add_vec(0, 0, 0, 0, NUM_COEFFS - 1, 0, 0, 0);
      add_vec(0, 0, 0, 0, NUM_COEFFS - 1, 0, 0, 0);
      foreach (vecs[i]) apply_vector(vecs[i]);

      prev_idx = NUM_COEFFS - 1;

      // Slow controller: modwait held high for five cycles per entry.
      do_reset();
      clear_obs();
      scen_d1 = 1;
      scen_h  = 5;
      nsf_reg = 1'b1;
      run_until_idle("slow_idle", 80);
      check_value("slow_load_count", obs_load_cyc.size(), NUM_COEFFS);
      for (int i = 1; i < NUM_COEFFS; i++) begin
         check_value("slow_spacing", obs_load_cyc[i] - obs_load_cyc[i-1], 7);
         check_value("slow_num", obs_load_num[i], i);
      end
      check_value("slow_done_after_fall", obs_clear_cyc[0] - (obs_load_cyc[NUM_COEFFS-1] + 1 + 5), 1);

      // Timeout: the controller ignores the first load, then behaves nominally on the retry.
      do_reset();
      clear_obs();
      scen_h       = 1;
      silent_coeff = 0;
      nsf_reg      = 1'b1;
      for (int n = 0; n < 60 && obs_err_cyc.size() == 0; n++) apply_stimulus();
      check_value("timeout_err_seen", obs_err_cyc.size(), 1);
      check_value("timeout_err_delay", obs_err_cyc[0] - obs_load_cyc[0], TIMEOUT + 1);
      check_value("timeout_no_clear", obs_clear_cyc.size(), 0);
      repeat (2) apply_stimulus();
      check_value("timeout_retry_count", obs_load_cyc.size(), 2);
      check_value("timeout_retry_delay", obs_load_cyc[1] - obs_err_cyc[0], 2);
      check_value("timeout_retry_num", obs_load_num[1], 0);
      run_until_idle("timeout_idle", 40);
      check_value("timeout_retry_clear", obs_clear_cyc.size(), 1);

      // Reset landing in WAIT_LO of entry 2, with the set still pending.
      do_reset();
      clear_obs();
      nsf_reg = 1'b1;
      for (int n = 0; n < 30 && obs_load_cyc.size() < 3; n++) apply_stimulus();
      apply_stimulus();
      rst_drv = 1'b1;
      apply_stimulus();
      rst_drv = 1'b0;
      apply_stimulus();
      check_value("midrst_num", int'(bus.coefficient_num), 0);
      check_value("midrst_busy", int'(bus.busy), 0);
      check_value("midrst_no_clear", obs_clear_cyc.size(), 0);
      apply_stimulus();
      check_value("midrst_restart_load", int'(bus.load_coeff), 1);
      check_value("midrst_restart_num", int'(bus.coefficient_num), 0);
      run_until_idle("midrst_idle", 40);
      check_value("midrst_total_loads", obs_load_cyc.size(), 3 + NUM_COEFFS);
      check_value("midrst_clear", obs_clear_cyc.size(), 1);

      // Start held off by a busy controller, then the flag dropped after the first load.
      do_reset();
      clear_obs();
      force_mw = 1'b1;
      nsf_reg  = 1'b1;
      repeat (5) apply_stimulus();
      check_value("blocked_no_load", obs_load_cyc.size(), 0);
      check_value("blocked_not_busy", int'(bus.busy), 0);
      force_mw = 1'b0;
      apply_stimulus();
      apply_stimulus();
      check_value("blocked_start_latency", obs_load_cyc.size(), 1);
      check_value("blocked_first_load", obs_load_cyc[0], cyc);
      nsf_reg = 1'b0;
      run_until_idle("drop_idle", 40);
      check_value("drop_load_count", obs_load_cyc.size(), NUM_COEFFS);
      check_value("drop_clear", obs_clear_cyc.size(), 1);

      // Random host requests, controller delays, flag drops, start blocking and resets.
      do_reset();
      clear_obs();
      scen_random = 1'b1;
      for (int n = 0; n < 1500; n++) begin
         if (!active && $urandom_range(0, 3) == 0) nsf_reg = 1'b1;
         if (active && $urandom_range(0, 40) == 0) nsf_reg = 1'b0;
         force_mw = !active && ($urandom_range(0, 4) == 0);
         rst_drv  = ($urandom_range(0, 150) == 0);
         apply_stimulus();
      end
      rst_drv  = 1'b0;
      force_mw = 1'b0;
      $display("[TB] random phase: %0d loads, %0d completions, %0d timeouts",
               obs_load_cyc.size(), obs_clear_cyc.size(), obs_err_cyc.size());

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
